// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Desc   : Shared types and default constants for the multi-port register file.
// Rev    : 1.0
// ============================================================================
package regfile_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        MODE_USR = 1'b0,
        MODE_EXC = 1'b1
    } mode_e;

    localparam int PC_IDX_DEF    = 15;
    localparam int BANK_LO_DEF   = 13;
    localparam int PC_OFFSET_DEF = 8;

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module : regfile_mp_if
// Desc   : Decode/writeback bus of the register file (read ports, two write ports, clear).
// Rev    : 1.0
// ============================================================================
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int N_RD   = 3
);
    logic [N_RD*ADDR_W-1:0] a_rd;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic                   we0;
    logic [ADDR_W-1:0]      a0;
    logic [DATA_W-1:0]      wd0;
    logic                   we1;
    logic [ADDR_W-1:0]      a1;
    logic [DATA_W-1:0]      wd1;
    logic [DATA_W-1:0]      r15;
    logic                   mode;
    logic                   clr_req;
    logic                   clr_busy;

    modport master (
        output a_rd, we0, a0, wd0, we1, a1, wd1, r15, mode, clr_req,
        input  rd_data, clr_busy
    );

    modport slave (
        input  a_rd, we0, a0, wd0, we1, a1, wd1, r15, mode, clr_req,
        output rd_data, clr_busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_clr_seq.sv
`default_nettype none
// ============================================================================
// Module : regfile_clr_seq
// Desc   : Clear sequencer; walks indices 0..PC_IDX-1, one per cycle, on request.
// Rev    : 1.0
// ============================================================================
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int PC_IDX = PC_IDX_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clr_req_i,
    output logic                   clr_busy_o,
    output logic                   clr_we_o,
    output logic [ADDR_W-1:0]      clr_idx_o
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PC_IDX - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign clr_busy_o = (state_q == CLEAR);
    assign clr_we_o   = (state_q == CLEAR);
    assign clr_idx_o  = idx_q;
endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : regfile_mp
// Desc   : Parametrised multi-port register file with mode banking, PC read
//          substitution and a sequenced clear. REGFILE_BYPASS_EN enables
//          same-cycle write-to-read forwarding.
// Rev    : 1.0
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int N_RD      = 3,
    parameter int PC_IDX    = PC_IDX_DEF,
    parameter int BANK_LO   = BANK_LO_DEF,
    parameter int PC_OFFSET = PC_OFFSET_DEF
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    regfile_mp_if.slave  bus
);
    localparam int NB = PC_IDX - BANK_LO;
    localparam int EW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] BANK_A = ADDR_W'(BANK_LO);

    // usr_q holds every stored index; exc_q holds the exception copies of banked ones
    logic [DATA_W-1:0] usr_q [PC_IDX];
    logic [DATA_W-1:0] usr_d [PC_IDX];
    logic [DATA_W-1:0] exc_q [NB];
    logic [DATA_W-1:0] exc_d [NB];

    logic              clr_busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              w_exc;
    logic              w_we [2];
    logic [ADDR_W-1:0] w_a  [2];
    logic [DATA_W-1:0] w_wd [2];
    logic [N_RD*DATA_W-1:0] rd_d;

    function automatic logic is_stored(input logic [ADDR_W-1:0] a);
        return (a < PC_A);
    endfunction

    function automatic logic is_banked(input logic [ADDR_W-1:0] a);
        return (a >= BANK_A) && (a < PC_A);
    endfunction

    function automatic logic [EW-1:0] exc_idx(input logic [ADDR_W-1:0] a);
        return EW'(a - BANK_A);
    endfunction

    regfile_clr_seq #(
        .ADDR_W (ADDR_W),
        .PC_IDX (PC_IDX)
    ) u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (bus.clr_req),
        .clr_busy_o (clr_busy),
        .clr_we_o   (clr_we),
        .clr_idx_o  (clr_idx)
    );

    assign w_exc   = (bus.mode == MODE_EXC);
    assign w_we[0] = bus.we0;
    assign w_a[0]  = bus.a0;
    assign w_wd[0] = bus.wd0;
    assign w_we[1] = bus.we1;
    assign w_a[1]  = bus.a1;
    assign w_wd[1] = bus.wd1;

    always_comb begin
        usr_d = usr_q;
        exc_d = exc_q;
        if (clr_we) begin
            usr_d[clr_idx] = '0;
            if (is_banked(clr_idx)) exc_d[exc_idx(clr_idx)] = '0;
        end else begin
            // Port 1 applied first so a same-address port 0 write overrides it
            for (int p = 1; p >= 0; p--) begin
                if (w_we[p] && is_stored(w_a[p])) begin
                    if (is_banked(w_a[p]) && w_exc) exc_d[exc_idx(w_a[p])] = w_wd[p];
                    else                            usr_d[w_a[p]]          = w_wd[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PC_IDX; i++) usr_q[i] <= '0;
            for (int i = 0; i < NB; i++)     exc_q[i] <= '0;
        end else begin
            usr_q <= usr_d;
            exc_q <= exc_d;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        rd_d = '0;
        for (int k = 0; k < N_RD; k++) begin
            a = bus.a_rd[k*ADDR_W +: ADDR_W];
            v = '0;
            if (a == PC_A)                v = bus.r15 + DATA_W'(PC_OFFSET);
            else if (is_banked(a) && w_exc) v = exc_q[exc_idx(a)];
            else if (is_stored(a))        v = usr_q[a];
`ifdef REGFILE_BYPASS_EN
            if (!clr_busy && is_stored(a)) begin
                if (bus.we1 && (bus.a1 == a)) v = bus.wd1;
                if (bus.we0 && (bus.a0 == a)) v = bus.wd0;
            end
`endif
            rd_d[k*DATA_W +: DATA_W] = v;
        end
    end

    assign bus.rd_data  = rd_d;
    assign bus.clr_busy = clr_busy;
endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_mp
// Desc   : Self-checking bench: directed vector table, corner sequences and
//          randomized traffic against an array-based reference model.
// Rev    : 1.0
// ============================================================================
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .N_RD(3)) bus ();

    regfile_mp u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_usr [15];
    logic [31:0] m_exc [2];
    int          m_cnt = 0;

    typedef struct {
        logic        mode;
        logic [31:0] r15;
        logic        we0;
        logic [3:0]  a0;
        logic [31:0] wd0;
        logic        we1;
        logic [3:0]  a1;
        logic [31:0] wd1;
        logic [3:0]  ra0, ra1, ra2;
        logic [31:0] e0, e1, e2;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(logic m, logic [31:0] r, logic w0, logic [3:0] x0, logic [31:0] d0,
                                logic w1, logic [3:0] x1, logic [31:0] d1,
                                logic [3:0] q0, logic [3:0] q1, logic [3:0] q2,
                                logic [31:0] y0, logic [31:0] y1, logic [31:0] y2);
        vec_t v;
        v.mode = m; v.r15 = r; v.we0 = w0; v.a0 = x0; v.wd0 = d0;
        v.we1 = w1; v.a1 = x1; v.wd1 = d1;
        v.ra0 = q0; v.ra1 = q1; v.ra2 = q2; v.e0 = y0; v.e1 = y1; v.e2 = y2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdk(input int k);
        return bus.rd_data[k*32 +: 32];
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] v;
        if (a == 4'd15)                 v = bus.r15 + 32'd8;
        else if (a >= 4'd13 && bus.mode) v = m_exc[a - 13];
        else                            v = m_usr[a];
`ifdef REGFILE_BYPASS_EN
        if (m_cnt == 0 && a != 4'd15) begin
            if (bus.we0 && bus.a0 == a)      v = bus.wd0;
            else if (bus.we1 && bus.a1 == a) v = bus.wd1;
        end
`endif
        return v;
    endfunction

    task automatic mwrite(input logic [3:0] a, input logic [31:0] d);
        if (a >= 4'd13 && bus.mode) m_exc[a - 13] = d;
        else                        m_usr[a] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_usr[i] = '0;
        for (int i = 0; i < 2; i++)  m_exc[i] = '0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        if (m_cnt > 0) begin
            int idx;
            idx = 15 - m_cnt;
            m_usr[idx] = '0;
            if (idx >= 13) m_exc[idx - 13] = '0;
            m_cnt--;
        end else begin
            if (bus.we1 && bus.a1 < 4'd15) mwrite(bus.a1, bus.wd1);
            if (bus.we0 && bus.a0 < 4'd15) mwrite(bus.a0, bus.wd0);
            if (bus.clr_req) m_cnt = 15;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.we0 = 0; bus.a0 = '0; bus.wd0 = '0;
        bus.we1 = 0; bus.a1 = '0; bus.wd1 = '0;
        bus.clr_req = 0;
    endtask

    task automatic set_rd(input logic [3:0] q0, input logic [3:0] q1, input logic [3:0] q2);
        bus.a_rd = {q2, q1, q0};
    endtask

    task automatic cmp_model(input string tag);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_rd%0d", tag, k), rdk(k), model_read(bus.a_rd[k*4 +: 4]));
        chk($sformatf("%s_busy", tag), {31'd0, bus.clr_busy}, {31'd0, m_cnt > 0});
    endtask

    task automatic fill_all();
        set_idle();
        bus.mode = 0;
        for (int i = 0; i < 15; i++) begin
            bus.we0 = 1; bus.a0 = 4'(i); bus.wd0 = 32'h1000 + 32'(i) + 1;
            tick();
        end
        bus.mode = 1;
        for (int i = 13; i < 15; i++) begin
            bus.we0 = 1; bus.a0 = 4'(i); bus.wd0 = 32'h2000 + 32'(i);
            tick();
        end
        set_idle();
        bus.mode = 0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int m = 0; m < 2; m++) begin
            bus.mode = m[0];
            for (int i = 0; i < 15; i++) begin
                set_rd(4'(i), 4'd15, 4'd0);
                #1;
                chk($sformatf("%s_m%0d_r%0d", tag, m, i), rdk(0), 32'h0);
            end
        end
        bus.mode = 0;
    endtask

    initial begin
        set_idle();
        bus.mode = 0;
        bus.r15 = 32'h100;
        set_rd(4'd0, 4'd5, 4'd15);
        model_reset();
        #2;
        chk("reset_rd0", rdk(0), 32'h0);
        chk("reset_rd1", rdk(1), 32'h0);
        chk("reset_rd2_pc", rdk(2), 32'h108);
        chk("reset_busy", {31'd0, bus.clr_busy}, 32'h0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Directed table: reads are checked before the edge that commits the record's writes
        vecs[0] = mk(0, 32'h100, 1, 2, 32'h12345678, 0, 0, 0, 0, 5, 15, 0, 0, 32'h108);
        vecs[1] = mk(0, 32'h100, 1, 15, 32'hDEAD, 0, 0, 0, 2, 15, 0, 32'h12345678, 32'h108, 0);
        vecs[2] = mk(0, 32'h100, 1, 4, 32'hAAAA0000, 1, 4, 32'hBBBB0000, 2, 3, 15, 32'h12345678, 0, 32'h108);
        vecs[3] = mk(0, 32'h100, 1, 6, 32'h66, 1, 5, 32'h55, 4, 2, 0, 32'hAAAA0000, 32'h12345678, 0);
        vecs[4] = mk(0, 32'h100, 1, 13, 32'h1111, 0, 0, 0, 5, 6, 4, 32'h55, 32'h66, 32'hAAAA0000);
        vecs[5] = mk(1, 32'h100, 0, 0, 0, 1, 13, 32'h2222, 14, 12, 5, 0, 0, 32'h55);
        vecs[6] = mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 13, 14, 15, 32'h2222, 0, 32'h208);
        vecs[7] = mk(0, 32'h200, 1, 12, 32'hCC, 0, 0, 0, 13, 11, 14, 32'h1111, 0, 0);
        vecs[8] = mk(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 13, 12, 15, 32'h2222, 32'hCC, 32'h4);
        vecs[9] = mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 13, 4, 5, 32'h1111, 32'hAAAA0000, 32'h55);
        for (int i = 0; i < 10; i++) begin
            bus.mode = vecs[i].mode; bus.r15 = vecs[i].r15;
            bus.we0 = vecs[i].we0; bus.a0 = vecs[i].a0; bus.wd0 = vecs[i].wd0;
            bus.we1 = vecs[i].we1; bus.a1 = vecs[i].a1; bus.wd1 = vecs[i].wd1;
            set_rd(vecs[i].ra0, vecs[i].ra1, vecs[i].ra2);
            #2;
            chk($sformatf("vec%0d_rd0", i), rdk(0), vecs[i].e0);
            chk($sformatf("vec%0d_rd1", i), rdk(1), vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), rdk(2), vecs[i].e2);
            tick();
        end
        set_idle();
        bus.mode = 0;
        bus.r15 = 32'h100;

        // Same-cycle forwarding (or not) of a write to a read of the same index
        bus.we0 = 1; bus.a0 = 3; bus.wd0 = 32'hCAFE;
        set_rd(4'd0, 4'd3, 4'd15);
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_r3", rdk(1), 32'hCAFE);
`else
        chk("nobypass_r3", rdk(1), 32'h0);
`endif
        tick();
        set_idle();
        #1;
        chk("r3_after_edge", rdk(1), 32'hCAFE);
        bus.we0 = 1; bus.a0 = 7; bus.wd0 = 32'h70;
        bus.we1 = 1; bus.a1 = 7; bus.wd1 = 32'h71;
        set_rd(4'd7, 4'd0, 4'd15);
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_prio_r7", rdk(0), 32'h70);
`else
        chk("nobypass_r7", rdk(0), 32'h0);
`endif
        tick();
        set_idle();
        #1;
        chk("r7_port0_wins", rdk(0), 32'h70);

        // Clear sequence with a write attempt and a repeated request while busy
        fill_all();
        bus.clr_req = 1;
        set_rd(4'd0, 4'd14, 4'd13);
        #2;
        cmp_model("clr_start");
        tick();
        for (int c = 0; c < 15; c++) begin
            bus.clr_req = (c == 1);
            bus.mode = c[0];
            bus.we0 = (c == 7); bus.a0 = 4'd0; bus.wd0 = 32'hBAD;
            set_rd(4'(c), 4'd14, 4'd13);
            #2;
            cmp_model($sformatf("clr_c%0d", c));
            chk($sformatf("clr_busy_c%0d", c), {31'd0, bus.clr_busy}, 32'h1);
            tick();
        end
        set_idle();
        #1;
        chk("clr_done_busy", {31'd0, bus.clr_busy}, 32'h0);
        check_all_zero("clr_zero");
        bus.we0 = 1; bus.a0 = 1; bus.wd0 = 32'h77;
        tick();
        set_idle();
        set_rd(4'd1, 4'd0, 4'd15);
        #1;
        chk("post_clr_write", rdk(0), 32'h77);

        // Asynchronous reset in the middle of a clear
        fill_all();
        bus.clr_req = 1;
        tick();
        bus.clr_req = 0;
        for (int c = 0; c < 5; c++) tick();
        #2;
        chk("mid_clr_busy", {31'd0, bus.clr_busy}, 32'h1);
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_abort_busy", {31'd0, bus.clr_busy}, 32'h0);
        check_all_zero("rst_zero");
        set_rd(4'd15, 4'd0, 4'd0);
        #1;
        chk("rst_pc_read", rdk(0), 32'h108);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            bus.we0 = 1'($urandom % 2); bus.a0 = 4'($urandom % 16); bus.wd0 = $urandom;
            bus.we1 = 1'($urandom % 2); bus.a1 = 4'($urandom % 16); bus.wd1 = $urandom;
            bus.mode = 1'($urandom % 2);
            bus.r15 = $urandom;
            bus.clr_req = ($urandom % 40) == 0;
            set_rd(4'($urandom % 16), 4'($urandom % 16), 4'($urandom % 16));
            #2;
            cmp_model($sformatf("rand%0d", n));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the processor datapath, replacing the fixed 16×32 two-read/one-write file. It adds configurable data width, depth and read-port count, a second write port, mode-banked registers (R13/R14 style), PC read substitution with offset, and a sequenced clear engine. It sits between decode (read addresses) and writeback (two result buses).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W
- N_RD, 3, number of read ports
- PC_IDX, 15, index returning the external PC; never stored
- BANK_LO, 13, first banked index; indices BANK_LO..PC_IDX-1 have two copies selected by mode
- PC_OFFSET, 8, constant added to r15 on PC reads
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- a_rd  in  N_RD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  read data; port k at [k*DATA_W +: DATA_W]
- we0 / a0 / wd0  in  1 / ADDR_W / DATA_W  write port 0 (ALU result)
- we1 / a1 / wd1  in  1 / ADDR_W / DATA_W  write port 1 (load / base writeback)
- r15  in  DATA_W  current PC from fetch
- mode  in  1  0 = user bank, 1 = exception bank
- clr_req  in  1  start clear sequence (sampled in IDLE)
- clr_busy  out  1  clear sequence in progress

## Operation
- Reset (rst low): all stored entries, both banks, forced to 0; FSM to IDLE; clr_busy 0. rd_data follows the zeroed contents (PC reads still return r15+PC_OFFSET).
- Reads are combinational. Address == PC_IDX -> r15 + PC_OFFSET, modulo 2**DATA_W. Index in [BANK_LO, PC_IDX) -> copy selected by current mode. Other indices -> single copy.
- Writes occur on rising clk when weN = 1 and the FSM is IDLE. Writes to PC_IDX are dropped. Writes to banked indices target the bank of the current mode.
- Both ports writing the same address in one cycle: port 0 wins; port 1 dropped.
- Clear FSM: IDLE --clr_req--> CLEAR. CLEAR walks index 0..PC_IDX-1, one index per cycle, zeroing it (both banks for banked indices). Last index -> IDLE. clr_req in CLEAR is ignored. we0/we1 are ignored throughout CLEAR. Reads in CLEAR return current contents (partially cleared).
- rst low mid-CLEAR: immediate abort to IDLE, everything zeroed.

## Timing
- Write latency: data written at edge N is visible on rd_data after edge N (without bypass).
- clr_busy rises the cycle after clr_req is sampled, stays high for exactly PC_IDX cycles (15 by default). First write is accepted at the edge where clr_busy is already low.
- Mode change takes effect combinationally on reads and at the next edge for writes.

## Configuration
- REGFILE_BYPASS_EN defined: a read address equal to an active write address (same bank, FSM IDLE, not PC_IDX) returns that write data in the same cycle. Port 0 has priority over port 1.
- Undefined: reads return the stored value until the edge commits the write.

## Structure
- Package regfile_pkg: FSM state enum (IDLE, CLEAR), mode enum (MODE_USR, MODE_EXC), default constants for PC_IDX, BANK_LO, PC_OFFSET.
- Sub-module regfile_clr_seq: clear FSM plus index counter. Outputs clr_busy, clr_idx and clr_we. The main module holds storage, the banking decode and the read muxes.

## Test plan
- Reset then read all ports: a_rd = {0,5,15}, r15 = 'h100 -> rd_data = {0, 0, 'h108}.
- we0 = 1, a0 = 2, wd0 = 'h12345678; next cycle a_rd[0] = 2 -> 'h12345678. Also write a0 = 15 -> PC read unchanged.
- Conflict: a0 = a1 = 4, wd0 = 'hAAAA0000, wd1 = 'hBBBB0000 -> R4 = 'hAAAA0000. Separate addresses 4 and 5 -> both written.
- Banking: mode 0, write R13 = 'h1111; mode 1, write R13 = 'h2222. Reading R13 with mode 0 returns 'h1111, with mode 1 returns 'h2222; R12 is unaffected by mode.
- Clear: fill R0..R14 with nonzero values, pulse clr_req -> clr_busy high 15 cycles, all entries 0, both banks. A write during busy is dropped. rst low at cycle 5 -> immediate IDLE with all entries 0.
- With REGFILE_BYPASS_EN: we0 = 1, a0 = 3, wd0 = 'hCAFE, a_rd[1] = 3 in the same cycle -> rd_data[1] = 'hCAFE before the edge. Without the macro, the old value is returned.
